// File: rtl/instruction_memory.sv
`default_nettype none
// ============================================================================
// Module      : instruction_memory
// Description : Streamed-load program store with zero-latency fetch for the
//               single-cycle core; optional fetch checking via IMEM_PC_CHECK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module instruction_memory #(
    parameter int          DEPTH = 256,
    parameter logic [31:0] NOP   = 32'h0000_0000,
    localparam int         AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load_start,
    input  logic          load_valid,
    input  logic [31:0]   load_data,
    input  logic          load_last,
    output logic          load_ready,
    input  logic [31:0]   pc,
    output logic [31:0]   komut,
    output logic          core_reset,
    output logic [AW:0]   loaded_count,
    output logic          hata
);

    localparam logic [1:0]  c_idle     = 2'd0;
    localparam logic [1:0]  c_load     = 2'd1;
    localparam logic [1:0]  c_run      = 2'd2;
    localparam logic [AW:0] c_depth    = DEPTH[AW:0];
    localparam logic [AW:0] c_last_idx = c_depth - 1'b1;

    logic [1:0]    r_state;
    logic [AW:0]   r_count;
    logic [31:0]   r_mem [DEPTH];

    logic          w_run;
    logic          w_accept;
    logic          w_write;
    logic          w_final_word;
    logic [AW-1:0] w_idx;
    logic          w_in_range;
    logic          w_fetch_ok;

    assign w_run        = (r_state == c_run);
    assign load_ready   = (r_state == c_load) && (r_count < c_depth);
    assign core_reset   = !w_run;
    assign loaded_count = r_count;

    assign w_accept     = load_valid && load_ready;
    // A word that arrives together with a restart belongs to the abandoned load.
    assign w_write      = w_accept && !load_start && !reset;
    assign w_final_word = load_last || (r_count == c_last_idx);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_idle;
            r_count <= '0;
        end else begin
            case (r_state)
                c_idle: begin
                    if (load_start) begin
                        r_state <= c_load;
                        r_count <= '0;
                    end
                end
                c_load: begin
                    if (load_start) begin
                        r_count <= '0;
                    end else if (w_accept) begin
                        r_count <= r_count + 1'b1;
                        if (w_final_word) begin
                            r_state <= c_run;
                        end
                    end
                end
                c_run: begin
                    if (load_start) begin
                        r_state <= c_load;
                        r_count <= '0;
                    end
                end
                default: begin
                    r_state <= c_idle;
                    r_count <= '0;
                end
            endcase
        end
    end

    // Storage is deliberately left uncleared; r_count gates every read.
    always_ff @(posedge clk) begin
        if (w_write) begin
            r_mem[r_count[AW-1:0]] <= load_data;
        end
    end

    assign w_idx      = pc[AW+1:2];
    assign w_in_range = ({1'b0, w_idx} < r_count);

`ifdef IMEM_PC_CHECK_EN
    assign w_fetch_ok = w_in_range && (pc[1:0] == 2'b00) && !(|pc[31:AW+2]);
    assign hata       = w_run && !w_fetch_ok;
`else
    logic [31-AW:0] w_unused_pc;

    // Byte offset and high address bits are dropped so fetches wrap modulo DEPTH.
    assign w_unused_pc = {pc[31:AW+2], pc[1:0]};
    assign w_fetch_ok  = w_in_range;
    assign hata        = 1'b0;
`endif

    assign komut = (w_run && w_fetch_ok) ? r_mem[w_idx] : NOP;

endmodule
`default_nettype wire

// File: tb/tb_instruction_memory.sv
`default_nettype none
// Testbench for instruction_memory: a DEPTH=256 instance for load/fetch
// sequences and a DEPTH=4 instance for the capacity-limit case.
module tb_instruction_memory;

    localparam logic [31:0] c_nop = 32'h0000_0000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;

    logic        a_load_start, a_load_valid, a_load_last, a_load_ready;
    logic [31:0] a_load_data, a_pc, a_komut;
    logic        a_core_reset, a_hata;
    logic [8:0]  a_loaded_count;

    logic        b_load_start, b_load_valid, b_load_last, b_load_ready;
    logic [31:0] b_load_data, b_pc, b_komut;
    logic        b_core_reset, b_hata;
    logic [2:0]  b_loaded_count;

    instruction_memory #(.DEPTH(256), .NOP(c_nop)) u_dut_a (
        .clk          (clk),
        .reset        (reset),
        .load_start   (a_load_start),
        .load_valid   (a_load_valid),
        .load_data    (a_load_data),
        .load_last    (a_load_last),
        .load_ready   (a_load_ready),
        .pc           (a_pc),
        .komut        (a_komut),
        .core_reset   (a_core_reset),
        .loaded_count (a_loaded_count),
        .hata         (a_hata)
    );

    instruction_memory #(.DEPTH(4), .NOP(c_nop)) u_dut_b (
        .clk          (clk),
        .reset        (reset),
        .load_start   (b_load_start),
        .load_valid   (b_load_valid),
        .load_data    (b_load_data),
        .load_last    (b_load_last),
        .load_ready   (b_load_ready),
        .pc           (b_pc),
        .komut        (b_komut),
        .core_reset   (b_core_reset),
        .loaded_count (b_loaded_count),
        .hata         (b_hata)
    );

    typedef struct packed {
        logic [31:0] komut;
        logic        hata;
    } exp_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] komut;
        logic        hata;
    } vec_t;

    int          checks = 0;
    int          errors = 0;
    exp_t        sb_q[$];
    logic [31:0] model_mem [256];
    int          model_cnt = 0;
    vec_t        vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // Expected result is queued as the address is driven and retired once the
    // combinational fetch has settled.
    task automatic fetch(input bit sel_b, input logic [31:0] pc,
                         input logic [31:0] exp_komut, input logic exp_hata);
        exp_t e;
        @(negedge clk);
        if (sel_b) b_pc = pc;
        else       a_pc = pc;
        e.komut = exp_komut;
        e.hata  = exp_hata;
        sb_q.push_back(e);
        #2;
        e = sb_q.pop_front();
        if (sel_b) begin
            check($sformatf("b_komut_pc%0h", pc), b_komut, e.komut);
            check($sformatf("b_hata_pc%0h", pc), 32'(b_hata), 32'(e.hata));
        end else begin
            check($sformatf("a_komut_pc%0h", pc), a_komut, e.komut);
            check($sformatf("a_hata_pc%0h", pc), 32'(a_hata), 32'(e.hata));
        end
    endtask

    task automatic fetch_model(input logic [31:0] pc);
        int          idx;
        logic        bad;
        logic [31:0] k;
        idx = int'(pc[9:2]);
`ifdef IMEM_PC_CHECK_EN
        bad = (pc[1:0] != 2'b00) || (pc >= 32'd1024) || (idx >= model_cnt);
`else
        bad = (idx >= model_cnt);
`endif
        k = bad ? c_nop : model_mem[idx];
`ifdef IMEM_PC_CHECK_EN
        fetch(1'b0, pc, k, bad);
`else
        fetch(1'b0, pc, k, 1'b0);
`endif
    endtask

    task automatic a_start();
        @(negedge clk);
        a_load_start = 1'b1;
        @(negedge clk);
        a_load_start = 1'b0;
    endtask

    // Called on a falling edge; presents one word for one cycle.
    task automatic a_word(input logic [31:0] data, input logic last);
        a_load_valid = 1'b1;
        a_load_data  = data;
        a_load_last  = last;
        #1;
        check("a_ready_for_word", 32'(a_load_ready), 32'd1);
        model_mem[model_cnt] = data;
        model_cnt++;
        @(negedge clk);
        a_load_valid = 1'b0;
        a_load_last  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset        = 1'b1;
        a_load_start = 1'b0; a_load_valid = 1'b0; a_load_last = 1'b0;
        a_load_data  = '0;   a_pc = '0;
        b_load_start = 1'b0; b_load_valid = 1'b0; b_load_last = 1'b0;
        b_load_data  = '0;   b_pc = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Idle with load_valid asserted: nothing may be taken.
        a_load_valid = 1'b1;
        a_load_data  = 32'hDEAD_BEEF;
        repeat (5) @(negedge clk);
        a_load_valid = 1'b0;
        #1;
        check("idle_core_reset", 32'(a_core_reset), 32'd1);
        check("idle_load_ready", 32'(a_load_ready), 32'd0);
        check("idle_komut", a_komut, c_nop);
        check("idle_count", 32'(a_loaded_count), 32'd0);
        check("idle_hata", 32'(a_hata), 32'd0);

        // Back-to-back load of four words.
        a_start();
        for (int i = 0; i < 4; i++) a_word(32'h1111_1111 * (i + 1), i == 3);
        #1;
        check("load4_count", 32'(a_loaded_count), 32'd4);
        check("load4_core_reset", 32'(a_core_reset), 32'd0);
        check("load4_ready", 32'(a_load_ready), 32'd0);

        vecs[0] = '{32'd0,  32'h1111_1111, 1'b0};
        vecs[1] = '{32'd4,  32'h2222_2222, 1'b0};
        vecs[2] = '{32'd8,  32'h3333_3333, 1'b0};
        vecs[3] = '{32'd12, 32'h4444_4444, 1'b0};
`ifdef IMEM_PC_CHECK_EN
        vecs[4] = '{32'd16,    c_nop, 1'b1};
        vecs[5] = '{32'h40C,   c_nop, 1'b1};
        vecs[6] = '{32'd2,     c_nop, 1'b1};
        vecs[7] = '{32'h400,   c_nop, 1'b1};
`else
        vecs[4] = '{32'd16,    c_nop,        1'b0};
        vecs[5] = '{32'h40C,   32'h4444_4444, 1'b0};
        vecs[6] = '{32'd2,     32'h1111_1111, 1'b0};
        vecs[7] = '{32'h400,   32'h1111_1111, 1'b0};
`endif
        for (int i = 0; i < 8; i++) fetch(1'b0, vecs[i].pc, vecs[i].komut, vecs[i].hata);

        // Restart from RUN, then a mid-load restart that discards its word.
        @(negedge clk);
        a_load_start = 1'b1;
        #1;
        check("run_start_core_reset_same_cycle", 32'(a_core_reset), 32'd0);
        @(negedge clk);
        a_load_start = 1'b0;
        #1;
        check("run_start_core_reset_next", 32'(a_core_reset), 32'd1);
        check("run_start_count", 32'(a_loaded_count), 32'd0);
        model_cnt = 0;
        a_word(32'hC000_0001, 1'b0);
        a_word(32'hC000_0002, 1'b0);
        a_load_start = 1'b1;
        a_load_valid = 1'b1;
        a_load_data  = 32'h0BAD_0BAD;
        @(negedge clk);
        a_load_start = 1'b0;
        a_load_valid = 1'b0;
        #1;
        check("restart_count", 32'(a_loaded_count), 32'd0);
        check("restart_ready", 32'(a_load_ready), 32'd1);
        model_cnt = 0;

        // Gapped stream: valid toggles every other cycle.
        for (int i = 0; i < 4; i++) begin
            a_word(32'hA000_0001 + i, i == 3);
            if (i != 3) begin
                #1;
                check($sformatf("gap_count_%0d", i), 32'(a_loaded_count), 32'(i + 1));
                @(negedge clk);
            end
        end
        #1;
        check("gap_count_final", 32'(a_loaded_count), 32'd4);
        check("gap_core_reset", 32'(a_core_reset), 32'd0);
        for (int i = 0; i < 5; i++) fetch_model(32'(4 * i));

        // Reset in the middle of a load, then reset colliding with load_start.
        a_start();
        a_word(32'h5555_0001, 1'b0);
        a_word(32'h5555_0002, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_cnt = 0;
        #1;
        check("midreset_count", 32'(a_loaded_count), 32'd0);
        check("midreset_core_reset", 32'(a_core_reset), 32'd1);
        check("midreset_ready", 32'(a_load_ready), 32'd0);
        check("midreset_komut", a_komut, c_nop);
        @(negedge clk);
        reset        = 1'b1;
        a_load_start = 1'b1;
        @(negedge clk);
        reset        = 1'b0;
        a_load_start = 1'b0;
        #1;
        check("reset_vs_start_ready", 32'(a_load_ready), 32'd0);
        check("reset_vs_start_core_reset", 32'(a_core_reset), 32'd1);
        a_start();
        a_word(32'h7777_7777, 1'b1);
        #1;
        check("reload1_count", 32'(a_loaded_count), 32'd1);
        check("reload1_core_reset", 32'(a_core_reset), 32'd0);
        fetch_model(32'd0);
        fetch_model(32'd4);

        // DEPTH=4 instance: six words without load_last, only four fit.
        @(negedge clk);
        b_load_start = 1'b1;
        @(negedge clk);
        b_load_start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            b_load_valid = 1'b1;
            b_load_data  = 32'hB000_0000 + i;
            #1;
            check($sformatf("b_ready_%0d", i), 32'(b_load_ready), (i < 4) ? 32'd1 : 32'd0);
            check($sformatf("b_count_%0d", i), 32'(b_loaded_count), (i < 4) ? 32'(i) : 32'd4);
            @(negedge clk);
        end
        b_load_valid = 1'b0;
        #1;
        check("b_full_core_reset", 32'(b_core_reset), 32'd0);
        check("b_full_ready", 32'(b_load_ready), 32'd0);
        for (int i = 0; i < 4; i++) fetch(1'b1, 32'(4 * i), 32'hB000_0000 + i, 1'b0);
`ifdef IMEM_PC_CHECK_EN
        fetch(1'b1, 32'd16, c_nop, 1'b1);
`else
        fetch(1'b1, 32'd16, 32'hB000_0000, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
